gforce_sequencer: RTL and testbench
===================================

# gforce_sequencer

Multi-cycle sequencer for the Gforce MIPS datapath. Accepts one instruction word per `newinstr` handshake, decodes the opcode, and steps the datapath through DECODE, EXECUTE, MEMORY and WRITEBACK. In each step it drives the static mux selects (RegDst, ALUSrc, MemtoReg, ALUOp) and single-cycle enable strobes to the register file, ALU and data memory. It sits between the instruction source and the `mipscpu` datapath and replaces the free-running combinational control path.

## Interface
Parameters:
- `CNT_W`, 16: width of the retired-instruction counter.
- `MEM_TIMEOUT`, 15: maximum number of MEMORY wait cycles before the access is aborted; must be ≥1.

Ports:
- `clock` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `newinstr` input 1: instruction-valid strobe.
- `instrword` input 32: instruction; sampled only when `newinstr && ready`.
- `alu_zero` input 1: ALU zero flag; sampled in EXECUTE.
- `mem_ready` input 1: data-memory completion; sampled only in MEMORY.
- `ready` output 1: high only in IDLE.
- `regdst`, `alusrc`, `memtoreg` output 1 each: datapath mux selects.
- `aluop` output 2: to ALUControl.
- `funct` output 6: latched `instrword[5:0]`.
- `rf_rd_en`, `alu_en`, `mem_rd`, `mem_wr`, `reg_wr` output 1 each: step strobes.
- `branch_taken` output 1: one-cycle pulse.
- `done` output 1: one-cycle pulse when an instruction retires.
- `err` output 1: one-cycle pulse on an illegal opcode or a memory timeout.
- `retired` output CNT_W: count of retired instructions.

## Operation
- States: IDLE, DECODE, EXECUTE, MEMORY, WRITEBACK. Encoding lives in the shared package.
- **IDLE**
  - `ready`=1.
  - On `newinstr`: latch `instrword` into `ir` and go to DECODE.
- **DECODE**
  - `rf_rd_en`=1.
  - Load the static selects from `ir[31:26]`:
    - 0 (R-type): regdst=1, alusrc=0, memtoreg=0, aluop=2.
    - 35 (lw): regdst=0, alusrc=1, memtoreg=1, aluop=0.
    - 43 (sw): regdst=0, alusrc=1, memtoreg=0, aluop=0.
    - 4 (beq, only if enabled): all selects 0, aluop=1.
  - Any other opcode: `err` pulse, all selects stay 0, return to IDLE with no retirement.
- **EXECUTE**
  - `alu_en`=1.
  - R-type goes to WRITEBACK; lw and sw go to MEMORY.
  - beq: `branch_taken`=`alu_zero`, `done`=1, then IDLE.
- **MEMORY**
  - `mem_rd` (lw) or `mem_wr` (sw) is held high every cycle until `mem_ready`.
  - On `mem_ready`: lw goes to WRITEBACK; sw pulses `done` and goes to IDLE.
  - A wait counter increments each MEMORY cycle without `mem_ready`. When it reaches `MEM_TIMEOUT`: `err` pulse, strobes drop, return to IDLE with no retirement.
- **WRITEBACK**
  - `reg_wr`=1 and `done`=1, then IDLE.
- Static selects and `funct` hold from DECODE until the instruction ends; they are 0 in IDLE.
- Strobes are 0 in every state not listed above.
- `retired` increments on each `done`, wraps modulo 2^CNT_W, and is not cleared by `err`.
- `newinstr` while `ready`=0 is ignored, with no side effects.

## Timing
- Reset (asynchronous, active-low):
  - state=IDLE, `ready`=1.
  - All other outputs 0, `retired`=0, `ir`=0, wait counter=0.
- Reset mid-instruction aborts immediately: no strobe survives, and `done`/`err` are not pulsed.
- All outputs decode from registered state and `ir`. `branch_taken` combines state with `alu_zero`.
- Latency when `newinstr` is accepted at edge N:
  - R-type: DECODE N+1, EXECUTE N+2, WRITEBACK/`done` N+3, `ready` N+4.
  - lw with `mem_ready` already high: MEMORY N+3, WRITEBACK N+4, `ready` N+5.
  - sw: `done` in the MEMORY cycle in which `mem_ready`=1.
  - beq: `done` at N+2.
- `mem_ready` high before MEMORY is entered has no effect. It is sampled in the first MEMORY cycle, giving a minimum of one MEMORY cycle.
- `newinstr` asserted in the cycle `ready` returns is accepted: back-to-back issue, with no bubble beyond IDLE.

## Configuration
- `GFORCE_BRANCH_EN` defined:
  - opcode 4 is legal and `branch_taken` is active.
- `GFORCE_BRANCH_EN` undefined:
  - opcode 4 raises `err` in DECODE.
  - `branch_taken` is tied to 0.

## Structure
- Shared package `gforce_pkg`:
  - opcode constants (`OP_RTYPE`=0, `OP_LW`=35, `OP_SW`=43, `OP_BEQ`=4);
  - ALUOp constants;
  - the state typedef and its encoding.
- One sub-module, `gforce_seq_decode`: combinational opcode → {selects, legal, class}.
- The FSM, wait counter and retire counter stay in the top module.

## Test plan
- Reset then R-type `0x00851020`, mem_ready=1:
  - `rf_rd_en`, `alu_en`, `reg_wr` pulse at N+1, N+2, N+3; regdst=1, aluop=2, funct=0x20.
  - `done` at N+3, `retired`=1.
- lw `0x8C820004` with mem_ready delayed 3 cycles:
  - `mem_rd` high for 4 MEMORY cycles, then WRITEBACK with memtoreg=1.
  - `done` at N+7.
- sw `0xAC820004` with mem_ready never asserted:
  - `mem_wr` high for 15 cycles, then `err` pulse.
  - `reg_wr` never asserted, `retired` unchanged.
- Opcode 0x3F:
  - `err` at N+1, `ready` at N+2, no strobes.
- beq `0x10850003` with alu_zero=1:
  - `branch_taken` and `done` at N+2.
  - Without `GFORCE_BRANCH_EN`: `err` at N+1 instead.
- Async reset asserted in MEMORY:
  - all outputs 0 in the same cycle, `ready`=1 after release.
  - A `newinstr` pulse while `ready`=0 is ignored.

Source files
------------

// File: rtl/gforce_pkg.sv
// Shared definitions for the Gforce multi-cycle sequencer: opcodes, ALUOp codes,
// FSM state encoding and the instruction class reported by the decoder.
package gforce_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;

   typedef enum logic [2:0] {
      StIdle,
      StDecode,
      StExecute,
      StMemory,
      StWriteback
   } state_e;

   typedef enum logic [1:0] {
      ClsRtype,
      ClsLw,
      ClsSw,
      ClsBeq
   } instr_cls_e;

endpackage

// File: rtl/gforce_seq_decode.sv
// Combinational opcode decoder: static datapath selects, legality and class.
// beq is only legal when GFORCE_BRANCH_EN is defined.
module gforce_seq_decode
   import gforce_pkg::*;
(
   input  logic [5:0]  opcode,
   output logic        regdst,
   output logic        alusrc,
   output logic        memtoreg,
   output logic [1:0]  aluop,
   output logic        legal,
   output instr_cls_e  cls
);

   always_comb begin
      regdst   = 1'b0;
      alusrc   = 1'b0;
      memtoreg = 1'b0;
      aluop    = ALUOP_ADD;
      legal    = 1'b0;
      cls      = ClsRtype;
      case (opcode)
         OP_RTYPE: begin
            regdst = 1'b1;
            aluop  = ALUOP_FUNCT;
            legal  = 1'b1;
            cls    = ClsRtype;
         end
         OP_LW: begin
            alusrc   = 1'b1;
            memtoreg = 1'b1;
            legal    = 1'b1;
            cls      = ClsLw;
         end
         OP_SW: begin
            alusrc = 1'b1;
            legal  = 1'b1;
            cls    = ClsSw;
         end
`ifdef GFORCE_BRANCH_EN
         OP_BEQ: begin
            aluop = ALUOP_SUB;
            legal = 1'b1;
            cls   = ClsBeq;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/gforce_sequencer.sv
// Multi-cycle control sequencer for the Gforce MIPS datapath (IDLE/DECODE/EXECUTE/MEMORY/
// WRITEBACK). Define GFORCE_BRANCH_EN to make beq legal and enable branch_taken.
module gforce_sequencer #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             newinstr,
   input  logic [31:0]      instrword,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             ready,
   output logic             regdst,
   output logic             alusrc,
   output logic             memtoreg,
   output logic [1:0]       aluop,
   output logic [5:0]       funct,
   output logic             rf_rd_en,
   output logic             alu_en,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             reg_wr,
   output logic             branch_taken,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] retired
);
   import gforce_pkg::*;

   localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

   state_e           state_q;
   logic [31:0]      ir_q;
   logic [WaitW-1:0] wait_q;
   logic [CNT_W-1:0] retired_q;

   logic       dec_regdst;
   logic       dec_alusrc;
   logic       dec_memtoreg;
   logic [1:0] dec_aluop;
   logic       dec_legal;
   instr_cls_e dec_cls;

   logic busy;
   logic mem_timeout;
   logic mem_active;

   gforce_seq_decode u_decode (
      .opcode   (ir_q[31:26]),
      .regdst   (dec_regdst),
      .alusrc   (dec_alusrc),
      .memtoreg (dec_memtoreg),
      .aluop    (dec_aluop),
      .legal    (dec_legal),
      .cls      (dec_cls)
   );

   // Only opcode and funct fields steer the sequencer.
   logic unused_ir;
   assign unused_ir = ^ir_q[25:6];

   always_comb begin
      busy        = (state_q != StIdle);
      mem_timeout = (state_q == StMemory) && (wait_q == WaitW'(MEM_TIMEOUT));
      mem_active  = (state_q == StMemory) && !mem_timeout;

      ready    = !busy;
      regdst   = busy & dec_regdst;
      alusrc   = busy & dec_alusrc;
      memtoreg = busy & dec_memtoreg;
      aluop    = busy ? dec_aluop : 2'b00;
      funct    = busy ? ir_q[5:0] : 6'b0;

      rf_rd_en = (state_q == StDecode);
      alu_en   = (state_q == StExecute);
      mem_rd   = mem_active && (dec_cls == ClsLw);
      mem_wr   = mem_active && (dec_cls == ClsSw);
      reg_wr   = (state_q == StWriteback);
      err      = ((state_q == StDecode) && !dec_legal) || mem_timeout;
      done     = (state_q == StWriteback)
              || ((state_q == StExecute) && (dec_cls == ClsBeq))
              || (mem_wr && mem_ready);
`ifdef GFORCE_BRANCH_EN
      branch_taken = (state_q == StExecute) && (dec_cls == ClsBeq) && alu_zero;
`else
      branch_taken = 1'b0;
`endif
   end

`ifndef GFORCE_BRANCH_EN
   logic unused_alu_zero;
   assign unused_alu_zero = alu_zero;
`endif

   assign retired = retired_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         ir_q      <= '0;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         if (done) begin
            retired_q <= retired_q + CNT_W'(1);
         end
         unique case (state_q)
            StIdle: begin
               if (newinstr) begin
                  ir_q    <= instrword;
                  state_q <= StDecode;
               end
            end
            StDecode: begin
               state_q <= dec_legal ? StExecute : StIdle;
            end
            StExecute: begin
               case (dec_cls)
                  ClsRtype: state_q <= StWriteback;
                  ClsBeq:   state_q <= StIdle;
                  default:  state_q <= StMemory;
               endcase
            end
            StMemory: begin
               // Timeout wins over a late mem_ready so the abort is deterministic.
               if (mem_timeout) begin
                  wait_q  <= '0;
                  state_q <= StIdle;
               end else if (mem_ready) begin
                  wait_q  <= '0;
                  state_q <= (dec_cls == ClsLw) ? StWriteback : StIdle;
               end else begin
                  wait_q <= wait_q + WaitW'(1);
               end
            end
            StWriteback: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gforce_sequencer.sv
// Self-checking bench for gforce_sequencer: directed vector table, async-reset sequence
// and randomized instruction stream against a trace-building reference model.
module tb_gforce_sequencer;

   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 15;
`ifdef GFORCE_BRANCH_EN
   localparam bit BrEn = 1'b1;
`else
   localparam bit BrEn = 1'b0;
`endif

   logic             clock;
   logic             reset;
   logic             newinstr;
   logic [31:0]      instrword;
   logic             alu_zero;
   logic             mem_ready;
   logic             ready;
   logic             regdst;
   logic             alusrc;
   logic             memtoreg;
   logic [1:0]       aluop;
   logic [5:0]       funct;
   logic             rf_rd_en;
   logic             alu_en;
   logic             mem_rd;
   logic             mem_wr;
   logic             reg_wr;
   logic             branch_taken;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] retired;

   gforce_sequencer #(
      .CNT_W       (CNT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .newinstr     (newinstr),
      .instrword    (instrword),
      .alu_zero     (alu_zero),
      .mem_ready    (mem_ready),
      .ready        (ready),
      .regdst       (regdst),
      .alusrc       (alusrc),
      .memtoreg     (memtoreg),
      .aluop        (aluop),
      .funct        (funct),
      .rf_rd_en     (rf_rd_en),
      .alu_en       (alu_en),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .reg_wr       (reg_wr),
      .branch_taken (branch_taken),
      .done         (done),
      .err          (err),
      .retired      (retired)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic       ready;
      logic       regdst;
      logic       alusrc;
      logic       memtoreg;
      logic [1:0] aluop;
      logic [5:0] funct;
      logic       rf_rd_en;
      logic       alu_en;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_wr;
      logic       branch_taken;
      logic       done;
      logic       err;
   } outs_t;

   typedef struct {
      int busy;
      int n_done;
      int n_err;
      int n_mem;
      int n_bt;
   } res_t;

   typedef struct {
      logic [31:0] word;
      logic        az;
      int          delay;   // MEMORY cycles before mem_ready rises, -1 = never
      int          busy;
      int          dn;
      int          er;
      int          mem;
      int          bt;
   } vec_t;

   int               checks;
   int               errors;
   logic [CNT_W-1:0] exp_retired;
   outs_t            exp_q[$];
   outs_t            idle_exp;

   function automatic outs_t get_outs();
      outs_t o;
      o.ready        = ready;
      o.regdst       = regdst;
      o.alusrc       = alusrc;
      o.memtoreg     = memtoreg;
      o.aluop        = aluop;
      o.funct        = funct;
      o.rf_rd_en     = rf_rd_en;
      o.alu_en       = alu_en;
      o.mem_rd       = mem_rd;
      o.mem_wr       = mem_wr;
      o.reg_wr       = reg_wr;
      o.branch_taken = branch_taken;
      o.done         = done;
      o.err          = err;
      return o;
   endfunction

   // Expected output per busy cycle, from the instruction's class and memory latency.
   function automatic void build_trace(input logic [31:0] w, input logic az, input int delay);
      outs_t base;
      outs_t c;
      int    kind;  // 0 R, 1 lw, 2 sw, 3 beq, -1 illegal
      logic [5:0] op;
      op = w[31:26];
      base = '0;
      base.funct = w[5:0];
      exp_q.delete();
      if (op == 6'd0) begin
         kind = 0; base.regdst = 1'b1; base.aluop = 2'd2;
      end else if (op == 6'd35) begin
         kind = 1; base.alusrc = 1'b1; base.memtoreg = 1'b1;
      end else if (op == 6'd43) begin
         kind = 2; base.alusrc = 1'b1;
      end else if (op == 6'd4 && BrEn) begin
         kind = 3; base.aluop = 2'd1;
      end else begin
         kind = -1;
      end
      c = base; c.rf_rd_en = 1'b1; c.err = (kind < 0);
      exp_q.push_back(c);
      if (kind < 0) return;
      c = base; c.alu_en = 1'b1;
      if (kind == 3) begin c.done = 1'b1; c.branch_taken = az; end
      exp_q.push_back(c);
      if (kind == 0) begin
         c = base; c.reg_wr = 1'b1; c.done = 1'b1;
         exp_q.push_back(c);
      end
      if (kind == 1 || kind == 2) begin
         for (int k = 0; k <= MEM_TIMEOUT; k++) begin
            c = base;
            if (k == MEM_TIMEOUT) begin
               c.err = 1'b1;
               exp_q.push_back(c);
               break;
            end
            if (kind == 1) c.mem_rd = 1'b1; else c.mem_wr = 1'b1;
            if (delay >= 0 && k >= delay) begin
               c.done = (kind == 2);
               exp_q.push_back(c);
               if (kind == 1) begin
                  c = base; c.reg_wr = 1'b1; c.done = 1'b1;
                  exp_q.push_back(c);
               end
               break;
            end
            exp_q.push_back(c);
         end
      end
   endfunction

   task automatic check_cycle(input string name, input outs_t exp);
      outs_t act;
      act = get_outs();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s outputs at %0t: got %h want %h", name, $time, act, exp);
      end
      checks++;
      if (retired !== exp_retired) begin
         errors++;
         $display("FAIL %s retired at %0t: got %0d want %0d", name, $time, retired, exp_retired);
      end
      if (exp.done) exp_retired = exp_retired + CNT_W'(1);
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         newinstr  = 1'b0;
         instrword = $urandom;
         mem_ready = 1'($urandom_range(0, 1));
         alu_zero  = 1'($urandom_range(0, 1));
         @(negedge clock);
         check_cycle("idle", idle_exp);
      end
   endtask

   // Issue one instruction and follow at most max_cyc busy cycles; busy-cycle newinstr is noise.
   task automatic run_instr(input logic [31:0] w, input logic az, input int delay,
                            input int max_cyc, output res_t r);
      int len;
      bit is_mem;
      r = '{default: 0};
      build_trace(w, az, delay);
      len = exp_q.size();
      if (len > max_cyc) len = max_cyc;
      is_mem = (w[31:26] == 6'd35) || (w[31:26] == 6'd43);
      @(posedge clock); #1;
      newinstr  = 1'b1;
      instrword = w;
      mem_ready = 1'($urandom_range(0, 1));
      alu_zero  = 1'($urandom_range(0, 1));
      @(negedge clock);
      check_cycle("accept", idle_exp);
      for (int i = 1; i <= len; i++) begin
         @(posedge clock); #1;
         newinstr  = 1'($urandom_range(0, 1));
         instrword = $urandom;
         alu_zero  = (i == 2) ? az : 1'($urandom_range(0, 1));
         if (is_mem && i >= 3) mem_ready = (delay >= 0) && (i - 3 >= delay);
         else mem_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
         check_cycle($sformatf("busy%0d op%0d", i, w[31:26]), exp_q[i-1]);
         if (!ready) r.busy++;
         if (done) r.n_done++;
         if (err) r.n_err++;
         if (mem_rd || mem_wr) r.n_mem++;
         if (branch_taken) r.n_bt++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[9];
      res_t        r;
      logic [31:0] w;
      int          delay;

      checks      = 0;
      errors      = 0;
      exp_retired = '0;
      idle_exp    = '0;
      idle_exp.ready = 1'b1;

      vecs[0] = '{32'h00851020, 1'b0,  0, 3, 1, 0, 0, 0};
      vecs[1] = '{32'h8C820004, 1'b0,  3, 7, 1, 0, 4, 0};
      vecs[2] = '{32'hAC820004, 1'b0, -1, 18, 0, 1, 15, 0};
      vecs[3] = '{32'hFC000000, 1'b0,  0, 1, 0, 1, 0, 0};
      vecs[4] = '{32'h10850003, 1'b1,  0, BrEn ? 2 : 1, BrEn ? 1 : 0, BrEn ? 0 : 1, 0,
                  BrEn ? 1 : 0};
      vecs[5] = '{32'h10850003, 1'b0,  0, BrEn ? 2 : 1, BrEn ? 1 : 0, BrEn ? 0 : 1, 0, 0};
      vecs[6] = '{32'h8C820004, 1'b0,  0, 4, 1, 0, 1, 0};
      vecs[7] = '{32'hAC820004, 1'b0,  2, 5, 1, 0, 3, 0};
      vecs[8] = '{32'h0022182A, 1'b0,  0, 3, 1, 0, 0, 0};

      reset     = 1'b0;
      newinstr  = 1'b0;
      instrword = '0;
      mem_ready = 1'b0;
      alu_zero  = 1'b0;
      #2;
      check_cycle("reset_state", idle_exp);
      @(posedge clock); #1;
      reset = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_instr(vecs[i].word, vecs[i].az, vecs[i].delay, 1000, r);
         chk_int($sformatf("vec%0d busy", i), r.busy, vecs[i].busy);
         chk_int($sformatf("vec%0d done", i), r.n_done, vecs[i].dn);
         chk_int($sformatf("vec%0d err", i), r.n_err, vecs[i].er);
         chk_int($sformatf("vec%0d mem", i), r.n_mem, vecs[i].mem);
         chk_int($sformatf("vec%0d branch", i), r.n_bt, vecs[i].bt);
      end

      // lw stalls in MEMORY, then an async reset lands mid-cycle
      run_instr(32'h8C820004, 1'b0, -1, 4, r);
      chk_int("pre_reset mem", r.n_mem, 2);
      #2;
      newinstr = 1'b0;
      reset    = 1'b0;
      #1;
      exp_retired = '0;
      check_cycle("reset_async", idle_exp);
      @(posedge clock); #1;
      check_cycle("reset_hold", idle_exp);
      reset = 1'b1;
      idle_cycles(1);

      for (int n = 0; n < 150; n++) begin
         w = $urandom;
         case ($urandom_range(0, 4))
            0: w[31:26] = 6'd0;
            1: w[31:26] = 6'd35;
            2: w[31:26] = 6'd43;
            3: w[31:26] = 6'd4;
            default: ;
         endcase
         if ($urandom_range(0, 9) == 0) delay = -1;
         else delay = int'($urandom_range(0, 6));
         run_instr(w, 1'($urandom_range(0, 1)), delay, 1000, r);
         chk_int($sformatf("rand%0d busy", n), r.busy, exp_q.size());
         if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
      end
      idle_cycles(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
